register_file: RTL and testbench

Architectural register file for the pipelined CPU: 32 × 64-bit registers, two combinational read ports for decode and one synchronous write port driven by writeback. The write address is one-hot decoded by a 5→32 decoder, built from gated 3→8 and 2→4 decoder stages, into per-register write enables. Register 31 is XZR: it always reads 0 and ignores writes. A same-cycle writeback→read bypass removes the WB/ID hazard, so the hazard unit needs no stall for that case.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/decoder_5x32.sv | 14 +
 rtl/register_file.sv | 46 ++++
 tb/tb_register_file.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register-index type and the XZR index for the CPU datapath
package cpu_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam logic [REG_ADDR_W-1:0] XZR_IDX = 5'd31;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/decoder_5x32.sv
// decoder_5x32: gated 2->4 group select driving four enabled 3->8 decoders
module decoder_5x32
    import cpu_pkg::*;
(
    input  logic        i_en,
    input  reg_addr_t   i_addr,
    output logic [31:0] o_decode
);
    logic [3:0] w_grp;
    assign w_grp = i_en ? 4'b0001 << i_addr[4:3] : 4'b0000;
    for (genvar g = 0; g < 4; g++) begin : g_grp
        assign o_decode[g*8 +: 8] = w_grp[g] ? 8'b0000_0001 << i_addr[2:0] : 8'b0000_0000;
    end
endmodule

// File: rtl/register_file.sv
// register_file: 32x64 architectural registers, two combinational reads with WB bypass, XZR hardwired to 0
module register_file
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  reg_addr_t             WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  reg_addr_t             ReadRegister1,
    input  reg_addr_t             ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);
    logic [31:0]           w_we;
    logic [DATA_WIDTH-1:0] w_rd [NUM_REGS];
    logic                  w_byp1, w_byp2;

    decoder_5x32 u_dec (
        .i_en     (RegWrite),
        .i_addr   (WriteRegister),
        .o_decode (w_we)
    );

    for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;
        // Enabled DFF per register; reset wins over a same-edge write
        always_ff @(posedge clk) begin
            if (reset)
                r_q <= '0;
            else if (w_we[r])
                r_q <= WriteData;
        end
        assign w_rd[r] = r_q;
    end
    assign w_rd[NUM_REGS-1] = '0;

    // Enable of the addressed register doubles as the address-match for the bypass
    assign w_byp1 = !reset && w_we[ReadRegister1] && ReadRegister1 != XZR_IDX;
    assign w_byp2 = !reset && w_we[ReadRegister2] && ReadRegister2 != XZR_IDX;
    assign ReadData1 = w_byp1 ? WriteData : w_rd[ReadRegister1];
    assign ReadData2 = w_byp2 ? WriteData : w_rd[ReadRegister2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array model
module tb_register_file;
    logic        clk = 1'b0;
    logic        reset, RegWrite;
    logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2;
    logic [63:0] WriteData, ReadData1, ReadData2;
    logic [63:0] model [32];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    function automatic logic [63:0] ref_read(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (!reset && RegWrite && WriteRegister == a) return WriteData;
        return model[a];
    endfunction

    task automatic clock_edge();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            model[WriteRegister] = WriteData;
        end
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        reset = 1'b0; RegWrite = 1'b1; WriteRegister = a; WriteData = d;
        clock_edge();
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b0;
        clock_edge();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
            #1;
            total += 2;
            if (ReadData1 !== 64'd0) begin bad++; $display("FAIL reset_rd1 idx=%0d got=%h exp=0", i, ReadData1); end
            if (ReadData2 !== 64'd0) begin bad++; $display("FAIL reset_rd2 idx=%0d got=%h exp=0", 31 - i, ReadData2); end
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 64'hDEAD_BEEF_0123_4567);
        write_reg(5'd30, 64'hFFFF_FFFF_FFFF_FFFF);
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd30;
        #1;
        total += 2;
        if (ReadData1 !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL wr_x5 got=%h exp=%h", ReadData1, 64'hDEAD_BEEF_0123_4567); end
        if (ReadData2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL wr_x30 got=%h exp=%h", ReadData2, 64'hFFFF_FFFF_FFFF_FFFF); end
        for (int i = 0; i < 32; i++) begin
            if (i == 5 || i == 30) continue;
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(i);
            #1;
            total += 2;
            if (ReadData1 !== 64'd0) begin bad++; $display("FAIL wr_other_rd1 idx=%0d got=%h exp=0", i, ReadData1); end
            if (ReadData2 !== 64'd0) begin bad++; $display("FAIL wr_other_rd2 idx=%0d got=%h exp=0", i, ReadData2); end
        end
    endtask

    task automatic test_xzr();
        reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'h1234;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd5;
        #1;
        total += 2;
        if (ReadData1 !== 64'd0) begin bad++; $display("FAIL xzr_same_cycle got=%h exp=0", ReadData1); end
        if (ReadData2 !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL xzr_x5_same_cycle got=%h exp=%h", ReadData2, 64'hDEAD_BEEF_0123_4567); end
        clock_edge();
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'd31;
            #1;
            total += 2;
            if (ReadData1 !== ref_read(5'(i))) begin bad++; $display("FAIL xzr_after idx=%0d got=%h exp=%h", i, ReadData1, ref_read(5'(i))); end
            if (ReadData2 !== 64'd0) begin bad++; $display("FAIL xzr_after_rd31 got=%h exp=0", ReadData2); end
        end
    endtask

    task automatic test_bypass();
        write_reg(5'd7, 64'h11);
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h22;
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        #1;
        total += 2;
        if (ReadData1 !== 64'h22) begin bad++; $display("FAIL byp_rd1_before got=%h exp=22", ReadData1); end
        if (ReadData2 !== 64'h22) begin bad++; $display("FAIL byp_rd2_before got=%h exp=22", ReadData2); end
        clock_edge();
        RegWrite = 1'b0;
        #1;
        total += 2;
        if (ReadData1 !== 64'h22) begin bad++; $display("FAIL byp_rd1_after got=%h exp=22", ReadData1); end
        if (ReadData2 !== 64'h22) begin bad++; $display("FAIL byp_rd2_after got=%h exp=22", ReadData2); end
    endtask

    task automatic test_regwrite0();
        write_reg(5'd3, 64'h33);
        RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'hABCD;
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            total += 2;
            if (ReadData1 !== 64'h33) begin bad++; $display("FAIL we0_rd1 cyc=%0d got=%h exp=33", k, ReadData1); end
            if (ReadData2 !== 64'h33) begin bad++; $display("FAIL we0_rd2 cyc=%0d got=%h exp=33", k, ReadData2); end
            clock_edge();
        end
    endtask

    task automatic test_reset_vs_write();
        write_reg(5'd9, 64'h55);
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h77;
        ReadRegister1 = 5'd9; ReadRegister2 = 5'd9;
        #1;
        total += 2;
        if (ReadData1 !== 64'h55) begin bad++; $display("FAIL rvw_nobyp_rd1 got=%h exp=55", ReadData1); end
        if (ReadData2 !== 64'h55) begin bad++; $display("FAIL rvw_nobyp_rd2 got=%h exp=55", ReadData2); end
        clock_edge();
        reset = 1'b0; RegWrite = 1'b0; ReadRegister2 = 5'd5;
        #1;
        total += 2;
        if (ReadData1 !== 64'd0) begin bad++; $display("FAIL rvw_x9_cleared got=%h exp=0", ReadData1); end
        if (ReadData2 !== 64'd0) begin bad++; $display("FAIL rvw_x5_cleared got=%h exp=0", ReadData2); end
        write_reg(5'd9, 64'h77);
        #1;
        total++;
        if (ReadData1 !== 64'h77) begin bad++; $display("FAIL rvw_write_lands got=%h exp=77", ReadData1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 24) == 0);
            RegWrite = ($urandom_range(0, 2) != 0);
            WriteRegister = 5'($urandom_range(0, 31));
            WriteData = {$urandom, $urandom};
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = 5'($urandom_range(0, 31));
            #1;
            total += 2;
            if (ReadData1 !== ref_read(ReadRegister1)) begin bad++; $display("FAIL rand_rd1 n=%0d idx=%0d got=%h exp=%h", n, ReadRegister1, ReadData1, ref_read(ReadRegister1)); end
            if (ReadData2 !== ref_read(ReadRegister2)) begin bad++; $display("FAIL rand_rd2 n=%0d idx=%0d got=%h exp=%h", n, ReadRegister2, ReadData2, ref_read(ReadRegister2)); end
            clock_edge();
        end
        reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(i);
            #1;
            total++;
            if (ReadData1 !== ref_read(5'(i))) begin bad++; $display("FAIL rand_sweep idx=%0d got=%h exp=%h", i, ReadData1, ref_read(5'(i))); end
        end
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'd0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        test_reset();
        test_write_read();
        test_xzr();
        test_bypass();
        test_regwrite0();
        test_reset_vs_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
